// File: rtl/decode_queue.sv
// Buffered RV32I/M decode stage: a circular (instruction, PC) queue whose head
// entry is decoded combinationally, with a sticky halt after ECALL/EBREAK leaves.
module decode_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter bit          ENABLE_M = 1'b1,
  parameter int unsigned PC_W     = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_ir,
  input  logic [PC_W-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_W-1:0]          out_pc,
  output logic [4:0]               srcreg1_num,
  output logic [4:0]               srcreg2_num,
  output logic [4:0]               dstreg_num,
  output logic [31:0]              imm,
  output logic [5:0]               alucode,
  output logic [1:0]               aluop1_type,
  output logic [1:0]               aluop2_type,
  output logic                     reg_we,
  output logic                     is_load,
  output logic                     is_store,
  output logic                     is_multiclock,
  output logic                     is_halt,
  output logic                     is_illegal,
  output logic [1:0]               ram_read_size,
  output logic [1:0]               ram_write_size,
  output logic                     ram_read_signed,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [5:0] ALU_LUI = 6'd0,  ALU_JAL = 6'd1,  ALU_JALR = 6'd2,
    ALU_BEQ = 6'd3, ALU_BNE = 6'd4, ALU_BLT = 6'd5, ALU_BGE = 6'd6, ALU_BLTU = 6'd7,
    ALU_BGEU = 6'd8, ALU_LB = 6'd9, ALU_LH = 6'd10, ALU_LW = 6'd11, ALU_LBU = 6'd12,
    ALU_LHU = 6'd13, ALU_SB = 6'd14, ALU_SH = 6'd15, ALU_SW = 6'd16, ALU_ADD = 6'd17,
    ALU_SUB = 6'd18, ALU_XOR = 6'd19, ALU_OR = 6'd20, ALU_AND = 6'd21, ALU_SLT = 6'd22,
    ALU_SLTU = 6'd23, ALU_SLL = 6'd24, ALU_SRL = 6'd25, ALU_SRA = 6'd26, ALU_MUL = 6'd27,
    ALU_MULH = 6'd28, ALU_MULHSU = 6'd29, ALU_MULHU = 6'd30, ALU_DIV = 6'd31,
    ALU_DIVU = 6'd32, ALU_REM = 6'd33, ALU_REMU = 6'd34, ALU_NOP = 6'd63;
  localparam logic [1:0] OP_TYPE_NONE = 2'd0, OP_TYPE_REG = 2'd1, OP_TYPE_IMM = 2'd2,
    OP_TYPE_PC = 2'd3;
  localparam logic [1:0] RAM_MODE_NONE = 2'd0, RAM_MODE_BYTE = 2'd1, RAM_MODE_HALF = 2'd2,
    RAM_MODE_WORD = 2'd3;
  localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111, OPC_JAL = 7'b1101111,
    OPC_JALR = 7'b1100111, OPC_BRANCH = 7'b1100011, OPC_LOAD = 7'b0000011,
    OPC_STORE = 7'b0100011, OPC_OPIMM = 7'b0010011, OPC_OP = 7'b0110011,
    OPC_FENCE = 7'b0001111, OPC_SYSTEM = 7'b1110011;

  typedef enum logic {RUN, HALTED} state_t;

  state_t             state, state_next;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [31:0]        ir_mem [DEPTH];
  logic [PC_W-1:0]    pc_mem [DEPTH];
  logic               push, pop;

  logic [31:0] head_ir;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
  logic [4:0]  d_rs1, d_rs2, d_rd;
  logic [31:0] d_imm;
  logic [5:0]  d_alu;
  logic [1:0]  d_op1, d_op2, d_rsize, d_wsize;
  logic        d_we, d_load, d_store, d_multi, d_halt, d_ill, d_rsigned;

  assign in_ready  = (state == RUN) && (count != CNT_W'(DEPTH));
  assign out_valid = (state == RUN) && (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_next;
  end

  // Halt is entered only when the ECALL/EBREAK entry actually leaves the queue.
  always_comb begin
    state_next = state;
    if (flush)                           state_next = RUN;
    else if (state == RUN && pop && d_halt) state_next = HALTED;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= PTR_W'(wr_ptr + 1'b1);
      if (pop)  rd_ptr <= PTR_W'(rd_ptr + 1'b1);
      if (push && !pop)      count <= CNT_W'(count + 1'b1);
      else if (pop && !push) count <= CNT_W'(count - 1'b1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      ir_mem[wr_ptr] <= in_ir;
      pc_mem[wr_ptr] <= in_pc;
    end
  end

  assign head_ir = ir_mem[rd_ptr];
  assign opcode  = head_ir[6:0];
  assign funct3  = head_ir[14:12];
  assign funct7  = head_ir[31:25];
  assign imm_i   = {{20{head_ir[31]}}, head_ir[31:20]};
  assign imm_s   = {{20{head_ir[31]}}, head_ir[31:25], head_ir[11:7]};
  assign imm_b   = {{20{head_ir[31]}}, head_ir[7], head_ir[30:25], head_ir[11:8], 1'b0};
  assign imm_u   = {head_ir[31:12], 12'd0};
  assign imm_j   = {{12{head_ir[31]}}, head_ir[19:12], head_ir[20], head_ir[30:21], 1'b0};
  assign imm_sh  = {27'd0, head_ir[24:20]};

  always_comb begin
    d_rs1 = head_ir[19:15];  d_rs2 = '0;  d_rd = head_ir[11:7];
    d_imm = '0;  d_alu = ALU_NOP;  d_op1 = OP_TYPE_NONE;  d_op2 = OP_TYPE_NONE;
    d_we = 1'b0;  d_load = 1'b0;  d_store = 1'b0;  d_multi = 1'b0;
    d_halt = 1'b0;  d_ill = 1'b0;  d_rsigned = 1'b0;
    d_rsize = RAM_MODE_NONE;  d_wsize = RAM_MODE_NONE;
    case (opcode)
      OPC_LUI: begin
        d_rs1 = '0; d_alu = ALU_LUI; d_op2 = OP_TYPE_IMM; d_imm = imm_u; d_we = 1'b1;
      end
      OPC_AUIPC: begin
        d_rs1 = '0; d_alu = ALU_ADD; d_op1 = OP_TYPE_IMM; d_op2 = OP_TYPE_PC;
        d_imm = imm_u; d_we = 1'b1;
      end
      OPC_JAL: begin
        d_rs1 = '0; d_alu = ALU_JAL; d_op2 = OP_TYPE_PC; d_imm = imm_j;
        d_we = (head_ir[11:7] != 5'd0);
      end
      OPC_JALR: begin
        d_alu = ALU_JALR; d_op1 = OP_TYPE_REG; d_op2 = OP_TYPE_PC; d_imm = imm_i;
        d_we = (head_ir[11:7] != 5'd0); d_ill = (funct3 != 3'd0);
      end
      OPC_BRANCH: begin
        d_rs2 = head_ir[24:20]; d_rd = '0; d_op1 = OP_TYPE_REG; d_op2 = OP_TYPE_REG; d_imm = imm_b;
        case (funct3)
          3'b000: d_alu = ALU_BEQ;
          3'b001: d_alu = ALU_BNE;
          3'b100: d_alu = ALU_BLT;
          3'b101: d_alu = ALU_BGE;
          3'b110: d_alu = ALU_BLTU;
          3'b111: d_alu = ALU_BGEU;
          default: d_ill = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        d_op1 = OP_TYPE_REG; d_op2 = OP_TYPE_IMM; d_imm = imm_i; d_we = 1'b1;
        d_load = 1'b1; d_rsigned = ~funct3[2];
        case (funct3)
          3'b000: begin d_alu = ALU_LB;  d_rsize = RAM_MODE_BYTE; end
          3'b001: begin d_alu = ALU_LH;  d_rsize = RAM_MODE_HALF; end
          3'b010: begin d_alu = ALU_LW;  d_rsize = RAM_MODE_WORD; end
          3'b100: begin d_alu = ALU_LBU; d_rsize = RAM_MODE_BYTE; end
          3'b101: begin d_alu = ALU_LHU; d_rsize = RAM_MODE_HALF; end
          default: d_ill = 1'b1;
        endcase
      end
      OPC_STORE: begin
        d_rs2 = head_ir[24:20]; d_rd = '0; d_op1 = OP_TYPE_REG; d_op2 = OP_TYPE_REG;
        d_imm = imm_s; d_store = 1'b1;
        case (funct3)
          3'b000: begin d_alu = ALU_SB; d_wsize = RAM_MODE_BYTE; end
          3'b001: begin d_alu = ALU_SH; d_wsize = RAM_MODE_HALF; end
          3'b010: begin d_alu = ALU_SW; d_wsize = RAM_MODE_WORD; end
          default: d_ill = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        d_op1 = OP_TYPE_REG; d_op2 = OP_TYPE_IMM; d_imm = imm_i; d_we = 1'b1;
        case (funct3)
          3'b000: d_alu = ALU_ADD;
          3'b010: d_alu = ALU_SLT;
          3'b011: d_alu = ALU_SLTU;
          3'b100: d_alu = ALU_XOR;
          3'b110: d_alu = ALU_OR;
          3'b111: d_alu = ALU_AND;
          3'b001: begin d_imm = imm_sh; d_alu = ALU_SLL; d_ill = (funct7 != 7'd0); end
          default: begin
            d_imm = imm_sh;
            if (funct7 == 7'b0000000)      d_alu = ALU_SRL;
            else if (funct7 == 7'b0100000) d_alu = ALU_SRA;
            else                           d_ill = 1'b1;
          end
        endcase
      end
      OPC_OP: begin
        d_rs2 = head_ir[24:20]; d_op1 = OP_TYPE_REG; d_op2 = OP_TYPE_REG; d_we = 1'b1;
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000: d_alu = ALU_ADD;
            3'b001: d_alu = ALU_SLL;
            3'b010: d_alu = ALU_SLT;
            3'b011: d_alu = ALU_SLTU;
            3'b100: d_alu = ALU_XOR;
            3'b101: d_alu = ALU_SRL;
            3'b110: d_alu = ALU_OR;
            default: d_alu = ALU_AND;
          endcase
        end else if (funct7 == 7'b0100000) begin
          case (funct3)
            3'b000: d_alu = ALU_SUB;
            3'b101: d_alu = ALU_SRA;
            default: d_ill = 1'b1;
          endcase
        end else if (funct7 == 7'b0000001 && ENABLE_M) begin
          d_multi = 1'b1;
          case (funct3)
            3'b000: d_alu = ALU_MUL;
            3'b001: d_alu = ALU_MULH;
            3'b010: d_alu = ALU_MULHSU;
            3'b011: d_alu = ALU_MULHU;
            3'b100: d_alu = ALU_DIV;
            3'b101: d_alu = ALU_DIVU;
            3'b110: d_alu = ALU_REM;
            default: d_alu = ALU_REMU;
          endcase
        end else begin
          d_ill = 1'b1;
        end
      end
      OPC_FENCE: ;
      OPC_SYSTEM: begin
        if (head_ir == 32'h0000_0073 || head_ir == 32'h0010_0073) d_halt = 1'b1;
        else d_ill = 1'b1;
      end
      default: d_ill = 1'b1;
    endcase
    // An illegal word must never cause a side effect downstream.
    if (d_ill) begin
      d_alu = ALU_NOP;  d_op1 = OP_TYPE_NONE;  d_op2 = OP_TYPE_NONE;
      d_we = 1'b0;  d_load = 1'b0;  d_store = 1'b0;  d_multi = 1'b0;  d_halt = 1'b0;
      d_rsize = RAM_MODE_NONE;  d_wsize = RAM_MODE_NONE;  d_rsigned = 1'b0;
    end
  end

  // Outputs sit at idle values whenever nothing is presented.
  always_comb begin
    out_pc = '0;  srcreg1_num = '0;  srcreg2_num = '0;  dstreg_num = '0;  imm = '0;
    alucode = ALU_NOP;  aluop1_type = OP_TYPE_NONE;  aluop2_type = OP_TYPE_NONE;
    reg_we = 1'b0;  is_load = 1'b0;  is_store = 1'b0;  is_multiclock = 1'b0;
    is_halt = 1'b0;  is_illegal = 1'b0;  ram_read_signed = 1'b0;
    ram_read_size = RAM_MODE_NONE;  ram_write_size = RAM_MODE_NONE;
    if (out_valid) begin
      out_pc = pc_mem[rd_ptr];  srcreg1_num = d_rs1;  srcreg2_num = d_rs2;  dstreg_num = d_rd;
      imm = d_imm;  alucode = d_alu;  aluop1_type = d_op1;  aluop2_type = d_op2;
      reg_we = d_we;  is_load = d_load;  is_store = d_store;  is_multiclock = d_multi;
      is_halt = d_halt;  is_illegal = d_ill;  ram_read_signed = d_rsigned;
      ram_read_size = d_rsize;  ram_write_size = d_wsize;
    end
  end
endmodule

// File: tb/tb_decode_queue.sv
// Randomised bench for decode_queue: two instances (M extension on/off) share
// stimulus and are compared against a queue-plus-table reference model.
module tb_decode_queue;
  localparam int unsigned DEPTH = 4;

  localparam logic [5:0] ALU_LUI = 6'd0, ALU_JAL = 6'd1, ALU_JALR = 6'd2, ALU_BEQ = 6'd3,
    ALU_BNE = 6'd4, ALU_BLT = 6'd5, ALU_BGE = 6'd6, ALU_BLTU = 6'd7, ALU_BGEU = 6'd8,
    ALU_LB = 6'd9, ALU_LH = 6'd10, ALU_LW = 6'd11, ALU_LBU = 6'd12, ALU_LHU = 6'd13,
    ALU_SB = 6'd14, ALU_SH = 6'd15, ALU_SW = 6'd16, ALU_ADD = 6'd17, ALU_SUB = 6'd18,
    ALU_XOR = 6'd19, ALU_OR = 6'd20, ALU_AND = 6'd21, ALU_SLT = 6'd22, ALU_SLTU = 6'd23,
    ALU_SLL = 6'd24, ALU_SRL = 6'd25, ALU_SRA = 6'd26, ALU_MUL = 6'd27, ALU_MULH = 6'd28,
    ALU_MULHSU = 6'd29, ALU_MULHU = 6'd30, ALU_DIV = 6'd31, ALU_DIVU = 6'd32,
    ALU_REM = 6'd33, ALU_REMU = 6'd34, ALU_NOP = 6'd63, XX = 6'd62;
  localparam logic [1:0] T_NONE = 2'd0, T_REG = 2'd1, T_IMM = 2'd2, T_PC = 2'd3;
  localparam logic [1:0] M_NONE = 2'd0, M_BYTE = 2'd1, M_HALF = 2'd2, M_WORD = 2'd3;

  localparam logic [5:0] BRA_TAB [8] = '{ALU_BEQ, ALU_BNE, XX, XX, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU};
  localparam logic [5:0] LD_TAB  [8] = '{ALU_LB, ALU_LH, ALU_LW, XX, ALU_LBU, ALU_LHU, XX, XX};
  localparam logic [5:0] ST_TAB  [8] = '{ALU_SB, ALU_SH, ALU_SW, XX, XX, XX, XX, XX};
  localparam logic [5:0] BAS_TAB [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
  localparam logic [5:0] ALT_TAB [8] = '{ALU_SUB, XX, XX, XX, XX, ALU_SRA, XX, XX};
  localparam logic [5:0] MUL_TAB [8] = '{ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  localparam logic [1:0] SZ_TAB  [8] = '{M_BYTE, M_HALF, M_WORD, M_NONE, M_BYTE, M_HALF, M_NONE, M_NONE};
  localparam logic [6:0] OPCS [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};

  typedef struct packed {
    logic [4:0] rs1, rs2, rd;
    logic [31:0] imm;
    logic [5:0] alu;
    logic [1:0] op1, op2;
    logic we, load, store, multi, halt, ill;
    logic [1:0] rsize, wsize;
    logic rsigned;
  } dec_t;

  logic clk, rst_n, flush, in_valid, out_ready;
  logic [31:0] in_ir, in_pc;

  logic in_ready_a, out_valid_a, we_a, load_a, store_a, multi_a, halt_a, ill_a, rsigned_a;
  logic [31:0] out_pc_a, imm_a;
  logic [4:0] rs1_a, rs2_a, rd_a;
  logic [5:0] alu_a;
  logic [1:0] op1_a, op2_a, rsize_a, wsize_a;
  logic [2:0] count_a;
  logic in_ready_b, out_valid_b, we_b, load_b, store_b, multi_b, halt_b, ill_b, rsigned_b;
  logic [31:0] out_pc_b, imm_b;
  logic [4:0] rs1_b, rs2_b, rd_b;
  logic [5:0] alu_b;
  logic [1:0] op1_b, op2_b, rsize_b, wsize_b;
  logic [2:0] count_b;

  decode_queue #(.DEPTH(DEPTH), .ENABLE_M(1'b1), .PC_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_ir(in_ir), .in_pc(in_pc), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_pc(out_pc_a), .srcreg1_num(rs1_a), .srcreg2_num(rs2_a), .dstreg_num(rd_a),
    .imm(imm_a), .alucode(alu_a), .aluop1_type(op1_a), .aluop2_type(op2_a),
    .reg_we(we_a), .is_load(load_a), .is_store(store_a), .is_multiclock(multi_a),
    .is_halt(halt_a), .is_illegal(ill_a), .ram_read_size(rsize_a),
    .ram_write_size(wsize_a), .ram_read_signed(rsigned_a), .count(count_a));

  decode_queue #(.DEPTH(DEPTH), .ENABLE_M(1'b0), .PC_W(32)) dut_nm (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_ir(in_ir), .in_pc(in_pc), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_pc(out_pc_b), .srcreg1_num(rs1_b), .srcreg2_num(rs2_b), .dstreg_num(rd_b),
    .imm(imm_b), .alucode(alu_b), .aluop1_type(op1_b), .aluop2_type(op2_b),
    .reg_we(we_b), .is_load(load_b), .is_store(store_b), .is_multiclock(multi_b),
    .is_halt(halt_b), .is_illegal(ill_b), .ram_read_size(rsize_b),
    .ram_write_size(wsize_b), .ram_read_signed(rsigned_b), .count(count_b));

  logic [67:0] dec_a, dec_b;
  assign dec_a = {rs1_a, rs2_a, rd_a, imm_a, alu_a, op1_a, op2_a, we_a, load_a, store_a,
                  multi_a, halt_a, ill_a, rsize_a, wsize_a, rsigned_a};
  assign dec_b = {rs1_b, rs2_b, rd_b, imm_b, alu_b, op1_b, op2_b, we_b, load_b, store_b,
                  multi_b, halt_b, ill_b, rsize_b, wsize_b, rsigned_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  logic [63:0] mq [$];
  bit halted = 1'b0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic dec_t ref_decode(input logic [31:0] ir, input bit m_en);
    dec_t d;
    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic [31:0] i_i, i_s, i_b, i_u, i_j;
    opc = ir[6:0];  f3 = ir[14:12];  f7 = ir[31:25];
    i_i = 32'($signed(ir[31:20]));
    i_s = 32'($signed({ir[31:25], ir[11:7]}));
    i_b = 32'($signed({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}));
    i_u = {ir[31:12], 12'd0};
    i_j = 32'($signed({ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}));
    d = '0;
    d.alu = ALU_NOP;
    d.rs1 = (opc == 7'h37 || opc == 7'h17 || opc == 7'h6F) ? 5'd0 : ir[19:15];
    d.rs2 = (opc == 7'h33 || opc == 7'h63 || opc == 7'h23) ? ir[24:20] : 5'd0;
    d.rd  = (opc == 7'h63 || opc == 7'h23) ? 5'd0 : ir[11:7];
    case (opc)
      7'h37: begin d.alu = ALU_LUI; d.op2 = T_IMM; d.imm = i_u; d.we = 1'b1; end
      7'h17: begin d.alu = ALU_ADD; d.op1 = T_IMM; d.op2 = T_PC; d.imm = i_u; d.we = 1'b1; end
      7'h6F: begin d.alu = ALU_JAL; d.op2 = T_PC; d.imm = i_j; d.we = (ir[11:7] != 0); end
      7'h67: begin
        d.alu = (f3 == 0) ? ALU_JALR : XX; d.op1 = T_REG; d.op2 = T_PC; d.imm = i_i;
        d.we = (ir[11:7] != 0);
      end
      7'h63: begin d.alu = BRA_TAB[f3]; d.op1 = T_REG; d.op2 = T_REG; d.imm = i_b; end
      7'h03: begin
        d.alu = LD_TAB[f3]; d.op1 = T_REG; d.op2 = T_IMM; d.imm = i_i; d.load = 1'b1;
        d.we = 1'b1; d.rsize = SZ_TAB[f3]; d.rsigned = (f3 < 3);
      end
      7'h23: begin
        d.alu = ST_TAB[f3]; d.op1 = T_REG; d.op2 = T_REG; d.imm = i_s; d.store = 1'b1;
        d.wsize = SZ_TAB[f3];
      end
      7'h13: begin
        d.op1 = T_REG; d.op2 = T_IMM; d.we = 1'b1;
        if (f3 == 1 || f3 == 5) begin
          d.imm = {27'd0, ir[24:20]};
          d.alu = (f7 == 0) ? BAS_TAB[f3] : (f3 == 5 && f7 == 7'h20) ? ALU_SRA : XX;
        end else begin
          d.imm = i_i; d.alu = BAS_TAB[f3];
        end
      end
      7'h33: begin
        d.op1 = T_REG; d.op2 = T_REG; d.we = 1'b1;
        if (f7 == 7'h00)               d.alu = BAS_TAB[f3];
        else if (f7 == 7'h20)          d.alu = ALT_TAB[f3];
        else if (f7 == 7'h01 && m_en) begin d.alu = MUL_TAB[f3]; d.multi = 1'b1; end
        else                           d.alu = XX;
      end
      7'h0F: ;
      7'h73: if (ir == 32'h73 || ir == 32'h100073) d.halt = 1'b1; else d.alu = XX;
      default: d.alu = XX;
    endcase
    if (d.alu == XX) begin
      d.ill = 1'b1; d.alu = ALU_NOP; d.op1 = T_NONE; d.op2 = T_NONE;
      d.we = 1'b0; d.load = 1'b0; d.store = 1'b0; d.multi = 1'b0; d.halt = 1'b0;
      d.rsize = M_NONE; d.wsize = M_NONE; d.rsigned = 1'b0;
    end
    return d;
  endfunction

  task automatic compare_all();
    logic ev, er;
    logic [63:0] h;
    dec_t ea, eb;
    logic [31:0] epc;
    ev = !halted && mq.size() != 0;
    er = !halted && mq.size() < DEPTH;
    ea = '0; ea.alu = ALU_NOP; eb = ea; epc = '0;
    if (ev) begin
      h = mq[0];
      ea = ref_decode(h[63:32], 1'b1);
      eb = ref_decode(h[63:32], 1'b0);
      epc = h[31:0];
    end
    check("hs_a", 128'({in_ready_a, out_valid_a, count_a}), 128'({er, ev, 3'(mq.size())}));
    check("hs_b", 128'({in_ready_b, out_valid_b, count_b}), 128'({er, ev, 3'(mq.size())}));
    check("pc_a", 128'(out_pc_a), 128'(epc));
    check("pc_b", 128'(out_pc_b), 128'(epc));
    check("dec_a", 128'(dec_a), 128'(ea));
    check("dec_b", 128'(dec_b), 128'(eb));
  endtask

  task automatic model_update();
    logic ev, er;
    logic [63:0] h;
    dec_t d;
    ev = !halted && mq.size() != 0;
    er = !halted && mq.size() < DEPTH;
    if (flush) begin
      mq.delete(); halted = 1'b0;
    end else begin
      if (ev && out_ready) begin
        h = mq.pop_front();
        d = ref_decode(h[63:32], 1'b1);
        if (d.halt) halted = 1'b1;
      end
      if (in_valid && er) mq.push_back({in_ir, in_pc});
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ir, input logic [31:0] pc,
                       input logic rdy, input logic fl);
    in_valid = v; in_ir = ir; in_pc = pc; out_ready = rdy; flush = fl;
  endtask

  function automatic logic [31:0] rand_ir();
    logic [31:0] r;
    int k;
    r = $urandom;
    k = $urandom_range(0, 15);
    if (k < 11)       r[6:0] = OPCS[k];
    else if (k == 11) r = ($urandom_range(0, 1) == 1) ? 32'h00100073 : 32'h00000073;
    case ($urandom_range(0, 3))
      0: r[31:25] = 7'h00;
      1: r[31:25] = 7'h20;
      2: r[31:25] = 7'h01;
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    #12;
    check("rst_in_ready", 128'(in_ready_a), 128'(1));
    check("rst_out_valid", 128'(out_valid_a), 128'(0));
    check("rst_count", 128'(count_a), 128'(0));
    check("rst_alucode", 128'(alu_a), 128'(ALU_NOP));
    compare_all();
    rst_n = 1'b1;
    @(posedge clk); #1;

    // addi x1,x0,5
    drive(1'b1, 32'h00500093, 32'h100, 1'b0, 1'b0); step();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0); #3;
    check("addi_valid", 128'(out_valid_a), 128'(1));
    check("addi_count", 128'(count_a), 128'(1));
    check("addi_rd", 128'(rd_a), 128'(1));
    check("addi_rs1", 128'(rs1_a), 128'(0));
    check("addi_imm", 128'(imm_a), 128'(5));
    check("addi_alu", 128'(alu_a), 128'(ALU_ADD));
    check("addi_op2", 128'(op2_a), 128'(T_IMM));
    check("addi_we", 128'(we_a), 128'(1));

    // fill, overflow attempt, drain
    for (int i = 1; i < 4; i++) begin
      drive(1'b1, 32'h00500093, 32'h100 + 32'(4 * i), 1'b0, 1'b0); step();
    end
    #3;
    check("full_ready", 128'(in_ready_a), 128'(0));
    check("full_count", 128'(count_a), 128'(4));
    drive(1'b1, 32'h00500093, 32'h200, 1'b0, 1'b0); step(); #3;
    check("full_hold", 128'(count_a), 128'(4));
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("drain_pc", 128'(out_pc_a), 128'(32'h100 + 32'(4 * i)));
      step(); #3;
    end
    check("empty_count", 128'(count_a), 128'(0));
    check("empty_valid", 128'(out_valid_a), 128'(0));

    // mul x3,x1,x2 with and without M
    drive(1'b1, 32'h022081B3, 32'h300, 1'b0, 1'b0); step();
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0); #3;
    check("mul_alu", 128'(alu_a), 128'(ALU_MUL));
    check("mul_multi", 128'(multi_a), 128'(1));
    check("nom_ill", 128'(ill_b), 128'(1));
    check("nom_we", 128'(we_b), 128'(0));
    check("nom_alu", 128'(alu_b), 128'(ALU_NOP));
    step();

    // lw x5,8(x2) then an all-ones word
    drive(1'b1, 32'h00812283, 32'h400, 1'b0, 1'b0); step();
    drive(1'b1, 32'hFFFFFFFF, 32'h404, 1'b0, 1'b0); step();
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0); #3;
    check("lw_load", 128'(load_a), 128'(1));
    check("lw_imm", 128'(imm_a), 128'(8));
    check("lw_size", 128'(rsize_a), 128'(M_WORD));
    check("lw_signed", 128'(rsigned_a), 128'(1));
    step(); #3;
    check("bad_ill", 128'(ill_a), 128'(1));
    check("bad_load", 128'(load_a), 128'(0));
    step();

    // ECALL then addi: halt, blocked push, flush release
    drive(1'b1, 32'h00000073, 32'h500, 1'b0, 1'b0); step();
    drive(1'b1, 32'h00500093, 32'h504, 1'b0, 1'b0); step();
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0); #3;
    check("ecall_halt", 128'(halt_a), 128'(1));
    check("ecall_we", 128'(we_a), 128'(0));
    step(); #3;
    check("halt_valid", 128'(out_valid_a), 128'(0));
    check("halt_ready", 128'(in_ready_a), 128'(0));
    check("halt_count", 128'(count_a), 128'(1));
    drive(1'b1, 32'h00500093, 32'h508, 1'b1, 1'b0); step(); #3;
    check("halt_hold", 128'(count_a), 128'(1));
    drive(1'b1, 32'h00500093, 32'h50C, 1'b1, 1'b1); step();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0); #3;
    check("flush_count", 128'(count_a), 128'(0));
    check("flush_ready", 128'(in_ready_a), 128'(1));

    // streaming push+pop across pointer wrap, then async reset mid-stream
    drive(1'b1, 32'h00500093, 32'h600, 1'b0, 1'b0); step();
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 32'h00500093, 32'h600 + 32'(4 * i), 1'b1, 1'b0); #3;
      check("stream_count", 128'(count_a), 128'(1));
      check("stream_pc", 128'(out_pc_a), 128'(32'h600 + 32'(4 * (i - 1))));
      step();
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 128'(out_valid_a), 128'(0));
    check("arst_count", 128'(count_a), 128'(0));
    mq.delete(); halted = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk); compare_all();
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // random traffic
    for (int c = 0; c < 800; c++) begin
      drive(1'($urandom_range(0, 9) < 7), rand_ir(), $urandom & 32'hFFFF_FFFC,
            1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 31) == 0));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
